// File: rtl/cdb_arb_bus_pkg.sv
// Shared defaults and helpers for the common data bus.
// Widths mirror the core-wide tag/data/RS defaults.
package cdb_arb_bus_pkg;

  localparam int CDB_NUM_SRC = 4;
  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_RS_W    = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Combinational round-robin arbiter: req/ptr in, one-hot grant,
// grant_idx and any_grant out. Search starts at ptr and wraps.
import cdb_arb_bus_pkg::*;

module cdb_rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any_grant
);

  logic [SW-1:0] j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = SW'((int'(ptr) + k) % N);
      if (!any_grant && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = j;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arb_bus.sv
// Multi-source CDB: per-source one-entry hold, round-robin pick,
// registered broadcast of tag/data/rs/src; flush drops in-flight.
import cdb_arb_bus_pkg::*;

module cdb_arb_bus #(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int TAG_WIDTH  = CDB_TAG_W,
  parameter int DATA_WIDTH = CDB_DATA_W,
  parameter int RS_WIDTH   = CDB_RS_W,
  localparam int SRC_W     = idx_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*RS_WIDTH-1:0]   src_rs,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [RS_WIDTH-1:0]           cdb_rs,
  output logic [SRC_W-1:0]              cdb_src
);

  logic [NUM_SRC-1:0]    pending;
  logic [TAG_WIDTH-1:0]  hold_tag  [NUM_SRC];
  logic [DATA_WIDTH-1:0] hold_data [NUM_SRC];
  logic [RS_WIDTH-1:0]   hold_rs   [NUM_SRC];
  logic [SRC_W-1:0]      rr_ptr;

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_grant;
  logic [NUM_SRC-1:0] xfer;
  logic [SRC_W-1:0]   ptr_nxt;

  cdb_rr_arbiter #(
    .N  (NUM_SRC),
    .SW (SRC_W)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A granted slot frees this cycle, so it may refill at once.
  assign src_ready = {NUM_SRC{!flush}} & (~pending | grant);
  assign xfer      = src_valid & src_ready;

  assign ptr_nxt = (grant_idx == SRC_W'(NUM_SRC - 1))
                 ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_rs    <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
        hold_rs[i]   <= '0;
      end
    end else if (flush) begin
      pending   <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (xfer[i]) begin
          hold_tag[i]  <= src_tag[i*TAG_WIDTH +: TAG_WIDTH];
          hold_data[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
          hold_rs[i]   <= src_rs[i*RS_WIDTH +: RS_WIDTH];
          pending[i]   <= 1'b1;
        end else if (grant[i]) begin
          pending[i]   <= 1'b0;
        end
      end
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_tag  <= hold_tag[grant_idx];
        cdb_data <= hold_data[grant_idx];
        cdb_rs   <= hold_rs[grant_idx];
        cdb_src  <= grant_idx;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

endmodule
